disp_7seg_mux: RTL and testbench

//  Time-multiplexed driver for the 4-digit 7-segment display on the Basys3 board.
//  - Sits inside top_DH, directly upstream of the board pins an/seg/dp.
//  - Takes a 4-digit BCD value (score, shot counter) plus decimal points on a load strobe.
//  - Double-buffers the value so the display changes only on frame boundaries.
//  - Scans the digits continuously and produces the active-low anode, segment and dp signals.

---
 rtl/disp_7seg_mux.sv | 143 ++++++++++++++
 tb/tb_disp_7seg_mux.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/disp_7seg_mux.sv
// Time-multiplexed 4-digit 7-segment driver with a double-buffered BCD value and active-low outputs.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1 of the active value.
module disp_7seg_mux #(
  parameter int DIGIT_CYCLES = 16250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic        frame_tick,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [1:0]    IDX_LAST = 2'd3;

  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   active_q, active_d;
  logic [3:0]    active_dp_q, active_dp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic          pending_q, pending_d;
  logic          tick_q, tick_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          digit_end;
  logic          commit;
  logic [3:0]    nibble;
  logic          blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign digit_end = (cyc_q == CYC_LAST);
  assign commit    = digit_end && (idx_q == IDX_LAST);
  assign nibble    = active_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // A slot is blank only if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = (active_q[15:12] == 4'h0);
      2'd2:    blank = (active_q[15:8]  == 8'h00);
      2'd1:    blank = (active_q[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Load lands after the commit decision, so a load on the commit edge waits a frame.
  always_comb begin
    cyc_d       = digit_end ? '0 : cyc_q + CW'(1);
    idx_d       = digit_end ? idx_q + 2'd1 : idx_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    if (commit && pending_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
      pending_d   = 1'b0;
    end
    if (load) begin
      shadow_d    = value_in;
      shadow_dp_d = dp_in;
      pending_d   = 1'b1;
    end
    tick_d = commit;
  end

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_decode(nibble);
    dp_d  = ~active_dp_q[idx_q];
    if (blank) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q       <= '0;
      idx_q       <= 2'd0;
      active_q    <= 16'h0000;
      active_dp_q <= 4'b0000;
      shadow_q    <= 16'h0000;
      shadow_dp_q <= 4'b0000;
      pending_q   <= 1'b0;
      tick_q      <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      cyc_q       <= cyc_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pending_q   <= pending_d;
      tick_q      <= tick_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = tick_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_disp_7seg_mux.sv
// Self-checking bench for disp_7seg_mux with DIGIT_CYCLES=4, comparing every cycle against a frame-arithmetic model.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_disp_7seg_mux;

  localparam int DC    = 4;
  localparam int FRAME = 4 * DC;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        pending;
  logic        frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors;
  int miscompares;

  // Reference state: edges since reset release plus the two value buffers.
  int          edgeNum;
  logic [15:0] mActive, mShadow;
  logic [3:0]  mActiveDp, mShadowDp;
  logic        mPending;
  logic [6:0]  segTab [16];

  disp_7seg_mux #(.DIGIT_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
    .pending(pending), .frame_tick(frame_tick), .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edgeNum);
    end
  endtask

  task automatic resetModel();
    edgeNum   = 0;
    mActive   = 16'h0000;
    mShadow   = 16'h0000;
    mActiveDp = 4'b0000;
    mShadowDp = 4'b0000;
    mPending  = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_an"},   {12'h0, an},          16'h000F);
    checkOutput({tag, "_seg"},  {9'h0, seg},          16'h007F);
    checkOutput({tag, "_dp"},   {15'h0, dp},          16'h0001);
    checkOutput({tag, "_pend"}, {15'h0, pending},     16'h0000);
    checkOutput({tag, "_tick"}, {15'h0, frame_tick},  16'h0000);
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare every output.
  task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic [3:0] dpv);
    int          slot;
    logic [3:0]  digit;
    logic        blankSlot;
    logic        isCommit;
    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp;
    load     = ld;
    value_in = val;
    dp_in    = dpv;
    @(posedge clk);
    edgeNum++;
    slot      = ((edgeNum - 1) / DC) % 4;
    digit     = 4'((mActive >> (4 * slot)) & 16'hF);
    blankSlot = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blankSlot = (slot > 0) && ((mActive >> (4 * slot)) == 16'h0000);
`endif
    expAn  = blankSlot ? 4'b1111 : (4'b1111 ^ 4'(1 << slot));
    expSeg = blankSlot ? 7'h7F   : segTab[digit];
    expDp  = blankSlot ? 1'b1    : !mActiveDp[slot];
    isCommit = (edgeNum % FRAME) == 0;
    if (isCommit && mPending) begin
      mActive   = mShadow;
      mActiveDp = mShadowDp;
      mPending  = 1'b0;
    end
    if (ld) begin
      mShadow   = val;
      mShadowDp = dpv;
      mPending  = 1'b1;
    end
    #1;
    load = 1'b0;
    checkOutput("an",   {12'h0, an},         {12'h0, expAn});
    checkOutput("seg",  {9'h0, seg},         {9'h0, expSeg});
    checkOutput("dp",   {15'h0, dp},         {15'h0, expDp});
    checkOutput("pend", {15'h0, pending},    {15'h0, mPending});
    checkOutput("tick", {15'h0, frame_tick}, {15'h0, isCommit});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 4'b0000);
  endtask

  // Stops one edge short of the commit edge, so the next applyStimulus lands on it.
  task automatic runToCommit();
    for (int i = 0; i < FRAME && ((edgeNum + 1) % FRAME) != 0; i++) idle(1);
  endtask

  initial begin
    logic [15:0] rv;
    vectors     = 0;
    miscompares = 0;
    segTab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    resetModel();
    rst      = 1'b1;
    load     = 1'b0;
    value_in = 16'h0000;
    dp_in    = 4'b0000;

    $display("[TB] step 1: reset hold and release");
    repeat (3) @(posedge clk);
    #1 checkResetOutputs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    checkOutput("first_an",  {12'h0, an}, 16'h000E);
    checkOutput("first_seg", {9'h0, seg}, 16'h0040);

    $display("[TB] step 2: free run");
    idle(2 * FRAME);

    $display("[TB] step 3: mid-frame load 1234");
    idle(5);
    applyStimulus(1'b1, 16'h1234, 4'b0001);
    runToCommit();
    idle(2 * FRAME);

    $display("[TB] step 4: load on commit edge while pending");
    idle(3);
    applyStimulus(1'b1, 16'h1234, 4'b0001);
    runToCommit();
    applyStimulus(1'b1, 16'h5678, 4'b1000);
    checkOutput("commit_pend", {15'h0, pending}, 16'h0001);
    idle(2 * FRAME);

    $display("[TB] step 5: hex nibble shows dash");
    applyStimulus(1'b1, 16'h00A0, 4'b0000);
    idle(2 * FRAME);

    $display("[TB] step 6: leading zeros");
    applyStimulus(1'b1, 16'h0042, 4'b0100);
    idle(2 * FRAME);

    $display("[TB] randomized loads");
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 4; j++) rv[4*j +: 4] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rv[15:8] = 8'h00;
      if ($urandom_range(0, 4) == 0) runToCommit();
      else idle(int'($urandom_range(0, 20)));
      applyStimulus(1'b1, rv, 4'($urandom_range(0, 15)));
    end
    idle(2 * FRAME);

    $display("[TB] step 7: reset mid-digit-2");
    for (int i = 0; i < FRAME && (edgeNum % FRAME) != 10; i++) idle(1);
    applyStimulus(1'b1, 16'h9999, 4'b1111);
    #2 rst = 1'b1;
    #1 checkResetOutputs("rst_async");
    @(negedge clk);
    resetModel();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    checkOutput("restart_an",  {12'h0, an}, 16'h000E);
    checkOutput("restart_seg", {9'h0, seg}, 16'h0040);
    idle(FRAME + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
